// File: rtl/matrix_scan.sv
// Row-scanning driver for a 16x16 LED matrix: serialises one row word per row period into
// external column/row shift registers, with the game state snapshotted once per frame.
module matrix_scan #(
   parameter int unsigned TIMERWIDTH = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  x,
   input  logic [3:0]  y,
   input  logic [15:0] lpaddle,
   input  logic [15:0] rpaddle,
   output logic        rclk,
   output logic        rsdi,
   output logic        csdi,
   output logic        cclk,
   output logic        le,
   output logic        oeb,
   output logic        frame
);

   typedef enum logic [2:0] {StBlank, StCol, StRow, StLatch, StDisplay} state_e;

   localparam int unsigned CW = (TIMERWIDTH > 5) ? TIMERWIDTH : 5;
   localparam logic [CW-1:0] ColLast  = CW'(31);
   localparam logic [CW-1:0] DispLast = CW'((32'd1 << TIMERWIDTH) - 32'd1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    row_q, row_d;
   logic          started_q;
   logic [3:0]    snap_x_q, snap_x_d, snap_y_q, snap_y_d;
   logic [15:0]   snap_l_q, snap_l_d, snap_r_q, snap_r_d;
   logic [15:0]   word;
   logic          rclk_d, rsdi_d, csdi_d, cclk_d, le_d, oeb_d, frame_d;

   function automatic logic [15:0] row_word(input logic [3:0] r, input logic [3:0] bx,
                                            input logic [3:0] by, input logic [15:0] lp,
                                            input logic [15:0] rp);
      logic [15:0] w;
      w = '0;
      if (by == r) w[bx] = 1'b1;
      w[0]  = w[0] | lp[r];
      w[15] = w[15] | rp[r];
      return w;
   endfunction

   // Next-state; the cycle after reset is always the frame's first BLANK.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CW'(1);
      row_d    = row_q;
      snap_x_d = snap_x_q;
      snap_y_d = snap_y_q;
      snap_l_d = snap_l_q;
      snap_r_d = snap_r_q;
      if (!started_q) begin
         state_d = StBlank;
         cnt_d   = '0;
         row_d   = '0;
      end else begin
         unique case (state_q)
            StBlank: begin
               if (row_q == 4'd0) begin
                  snap_x_d = x;
                  snap_y_d = y;
                  snap_l_d = lpaddle;
                  snap_r_d = rpaddle;
               end
               state_d = StCol;
               cnt_d   = '0;
            end
            StCol: begin
               if (cnt_q == ColLast) begin
                  state_d = StRow;
                  cnt_d   = '0;
               end
            end
            StRow: begin
               if (cnt_q == CW'(1)) begin
                  state_d = StLatch;
                  cnt_d   = '0;
               end
            end
            StLatch: begin
               state_d = StDisplay;
               cnt_d   = '0;
            end
            StDisplay: begin
               if (cnt_q == DispLast) begin
                  state_d = StBlank;
                  cnt_d   = '0;
                  row_d   = row_q + 4'd1;
               end
            end
            default: begin
               state_d = StBlank;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the upcoming state so the pins are registered with it.
   always_comb begin
      word    = row_word(row_d, snap_x_d, snap_y_d, snap_l_d, snap_r_d);
      rclk_d  = 1'b0;
      rsdi_d  = 1'b0;
      csdi_d  = 1'b0;
      cclk_d  = 1'b0;
      le_d    = 1'b0;
      oeb_d   = 1'b1;
      frame_d = 1'b0;
      unique case (state_d)
         StBlank:   frame_d = (row_d == 4'd0);
         StCol: begin
            cclk_d = cnt_d[0];
            csdi_d = word[4'd15 - cnt_d[4:1]];
         end
         StRow: begin
            rclk_d = cnt_d[0];
            rsdi_d = (row_d == 4'd0);
         end
         StLatch:   le_d  = 1'b1;
         StDisplay: oeb_d = 1'b0;
         default:   oeb_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StBlank;
         cnt_q     <= '0;
         row_q     <= '0;
         started_q <= 1'b0;
         snap_x_q  <= '0;
         snap_y_q  <= '0;
         snap_l_q  <= '0;
         snap_r_q  <= '0;
         rclk      <= 1'b0;
         rsdi      <= 1'b0;
         csdi      <= 1'b0;
         cclk      <= 1'b0;
         le        <= 1'b0;
         oeb       <= 1'b1;
         frame     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         row_q     <= row_d;
         started_q <= 1'b1;
         snap_x_q  <= snap_x_d;
         snap_y_q  <= snap_y_d;
         snap_l_q  <= snap_l_d;
         snap_r_q  <= snap_r_d;
         rclk      <= rclk_d;
         rsdi      <= rsdi_d;
         csdi      <= csdi_d;
         cclk      <= cclk_d;
         le        <= le_d;
         oeb       <= oeb_d;
         frame     <= frame_d;
      end
   end

endmodule

// File: tb/tb_matrix_scan.sv
// Scoreboard bench for matrix_scan: the stimulus pushes expected row words per frame, and a
// monitor rebuilds rows from the shift-register pins and checks them plus the frame timing.
module tb_matrix_scan;

   localparam int unsigned TW = 4;
   localparam int DispLen     = 1 << TW;
   localparam int FramePeriod = 16 * (36 + DispLen);

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  x, y;
   logic [15:0] lpaddle, rpaddle;
   logic        rclk, rsdi, csdi, cclk, le, oeb, frame;

   typedef struct packed {
      logic [3:0]  row;
      logic [15:0] word;
   } exp_t;

   exp_t        exp_q[$];
   int          nvec = 0;
   int          nmis = 0;
   logic [15:0] cur_l, cur_r;
   logic [3:0]  cur_x, cur_y;

   matrix_scan #(.TIMERWIDTH(TW)) dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .lpaddle(lpaddle), .rpaddle(rpaddle),
      .rclk(rclk), .rsdi(rsdi), .csdi(csdi), .cclk(cclk), .le(le), .oeb(oeb), .frame(frame)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      nvec++;
      if (act != req) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Lit columns of a row, straight from the game rules.
   function automatic logic [15:0] model_word(input logic [15:0] lp, input logic [15:0] rp,
                                              input int bx, input int by, input int r);
      logic [15:0] w;
      w = '0;
      for (int c = 0; c < 16; c++)
         if ((c == 0 && lp[r]) || (c == 15 && rp[r]) || (by == r && bx == c)) w[c] = 1'b1;
      return w;
   endfunction

   task automatic new_frame(input int idx);
      exp_t e;
      case (idx)
         0: begin cur_l = 16'h0000; cur_r = 16'h0000; cur_x = 4'd5; cur_y = 4'd0; end
         1: begin cur_l = 16'h0007; cur_r = 16'h8000; cur_x = 4'd8; cur_y = 4'd3; end
         2: begin cur_l = 16'h0004; cur_r = 16'h0000; cur_x = 4'd0; cur_y = 4'd2; end
         3: begin
            cur_l = 16'($urandom); cur_r = 16'($urandom); cur_x = 4'd5; cur_y = 4'($urandom);
         end
         4: cur_x = 4'd9;
         default: begin
            cur_l = 16'($urandom); cur_r = 16'($urandom);
            cur_x = 4'($urandom);  cur_y = 4'($urandom);
         end
      endcase
      lpaddle = cur_l; rpaddle = cur_r; x = cur_x; y = cur_y;
      for (int r = 0; r < 16; r++) begin
         e.row  = 4'(r);
         e.word = model_word(cur_l, cur_r, int'(cur_x), int'(cur_y), r);
         exp_q.push_back(e);
      end
   endtask

   task automatic junk_inputs();
      lpaddle = 16'($urandom); rpaddle = 16'($urandom); x = 4'($urandom); y = 4'($urandom);
   endtask

   // Entered just after the edge that starts a frame's BLANK cycle; consumes one frame.
   task automatic run_frames(input int first, input int count, input bit push_last);
      for (int f = first; f < first + count; f++) begin
         @(negedge clk);
         check("frame_pulse", int'(frame), 1);
         @(posedge clk);
         @(negedge clk);
         check("frame_low", int'(frame), 0);
         junk_inputs();
         repeat (400) @(posedge clk);
         @(negedge clk);
         if (f == 3) begin
            lpaddle = cur_l; rpaddle = cur_r; y = cur_y; x = 4'd9;
         end else begin
            junk_inputs();
         end
         repeat (400) @(posedge clk);
         @(negedge clk);
         if (f < first + count - 1 || push_last) new_frame(f + 1);
         repeat (31) @(posedge clk);
      end
   endtask

   initial begin
      reset = 1'b1;
      new_frame(0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_oeb", int'(oeb), 1);
      check("rst_rclk", int'(rclk), 0);
      check("rst_rsdi", int'(rsdi), 0);
      check("rst_csdi", int'(csdi), 0);
      check("rst_cclk", int'(cclk), 0);
      check("rst_le", int'(le), 0);
      check("rst_frame", int'(frame), 0);
      reset = 1'b0;
      @(posedge clk);
      run_frames(0, 8, 1'b1);
      // Now in the BLANK cycle of a frame; advance to COL k=6 and reset there.
      repeat (13) @(posedge clk);
      @(negedge clk);
      check("pre_rst_cclk", int'(cclk), 0);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_oeb", int'(oeb), 1);
      check("mid_rst_cclk", int'(cclk), 0);
      check("mid_rst_le", int'(le), 0);
      exp_q.delete();
      new_frame(20);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      run_frames(20, 2, 1'b0);
      check("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   // Monitor: models the external shift registers and checks pin-level behaviour.
   logic        rst_q = 1'b1;
   bit          mon_en = 1'b0;
   bit          p_cclk, p_rclk, p_csdi, p_rsdi, p_le;
   bit          p_oeb = 1'b1;
   logic [15:0] colw = '0;
   logic [3:0]  row_idx = '0;
   int          since_frame = -1;
   int          le_cnt = 0;
   int          low_run = 0;

   always @(posedge clk) begin
      rst_q  <= reset;
      mon_en <= 1'b1;
   end

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (rst_q) begin
            since_frame = -1;
            le_cnt      = 0;
            low_run     = 0;
         end else begin
            if (since_frame >= 0) since_frame++;
            if (frame) begin
               if (since_frame >= 0) begin
                  check("frame_period", since_frame, FramePeriod);
                  check("le_per_frame", le_cnt, 16);
               end
               since_frame = 0;
               le_cnt      = 0;
            end
            if (cclk && !p_cclk) begin
               if (csdi != p_csdi) begin
                  nmis++;
                  $display("FAIL csdi_setup: got %0b, expected %0b at %0t", csdi, p_csdi, $time);
               end
               colw = {colw[14:0], csdi};
            end
            if (rclk && !p_rclk) begin
               if (rsdi != p_rsdi) begin
                  nmis++;
                  $display("FAIL rsdi_setup: got %0b, expected %0b at %0t", rsdi, p_rsdi, $time);
               end
               row_idx = rsdi ? 4'd0 : row_idx + 4'd1;
            end
            if (le && !p_le) begin
               le_cnt++;
               if (oeb != 1'b1) begin
                  nmis++;
                  $display("FAIL le_oeb: got oeb %0b, expected 1 at %0t", oeb, $time);
               end
               if (exp_q.size() == 0) begin
                  nmis++;
                  $display("FAIL unexpected_row: got row %0d word %0h, expected none at %0t",
                           row_idx, colw, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("row_index", int'(row_idx), int'(e.row));
                  check("row_word", int'(colw), int'(e.word));
               end
            end
            if (!oeb) begin
               low_run++;
               if (p_oeb && !p_le) begin
                  nmis++;
                  $display("FAIL display_entry: got le %0b before display, expected 1 at %0t",
                           p_le, $time);
               end
            end else if (!p_oeb) begin
               check("display_len", low_run, DispLen);
               low_run = 0;
            end
         end
         p_cclk = cclk; p_rclk = rclk; p_csdi = csdi; p_rsdi = rsdi;
         p_le = le;     p_oeb = oeb;
      end
   end

endmodule
